candidate_generator: RTL and testbench

Upstream password-candidate source for the MD5 controller. It enumerates strings over a fixed 62-symbol charset in order of increasing length, then lexicographic order within each length, as a base-62 odometer. Multiple cracking lanes are interleaved via a starting offset and a stride. Each candidate is presented right-aligned in a 128-bit word, with its length in bits, over a valid/ready handshake that the controller drives from the hasher's ready.

---
 rtl/md5_pkg.sv | 27 ++
 rtl/charset_odometer.sv | 55 +++++
 rtl/candidate_generator.sv | 109 ++++++++++
 tb/tb_candidate_generator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared definitions for the password-candidate path: charset constants,
// generator FSM encoding and the digit-index to ASCII map.
package md5_pkg;

  localparam int CHARSET_SIZE  = 62;
  localparam int IDX_W         = 6;
  localparam int MAX_CHARS_DEF = 8;
  localparam int LEN_W         = 5;   // holds lengths 1..16

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_EMIT,
    ST_STEP,
    ST_DONE
  } gen_state_t;

  // a-z, then A-Z, then 0-9
  function automatic logic [7:0] idx_to_ascii(input logic [IDX_W-1:0] idx);
    logic [7:0] w;
    w = {2'b00, idx};
    if (w < 8'd26)      return 8'h61 + w;
    else if (w < 8'd52) return 8'h41 + (w - 8'd26);
    else                return 8'h30 + (w - 8'd52);
  endfunction

endpackage

// File: rtl/charset_odometer.sv
// Base-62 odometer: digit0 is the last character. A carry out of the top
// used digit grows the length and restarts at all-'a'. When growth would
// exceed MAX_CHARS the state is frozen and overflow flags it.
module charset_odometer
  import md5_pkg::*;
#(
  parameter int MAX_CHARS = MAX_CHARS_DEF
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            load,
  input  logic                            advance,
  output logic [MAX_CHARS-1:0][IDX_W-1:0] digits,
  output logic [LEN_W-1:0]                len,
  output logic                            overflow
);

  logic [MAX_CHARS-1:0][IDX_W-1:0] nxt_digits;
  logic                            carry_out;

  // ripple the +1 through the used digits
  always_comb begin
    logic c;
    c          = 1'b1;
    nxt_digits = digits;
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (c && (i < int'(len))) begin
        if (digits[i] == IDX_W'(CHARSET_SIZE - 1)) begin
          nxt_digits[i] = '0;
        end else begin
          nxt_digits[i] = digits[i] + IDX_W'(1);
          c             = 1'b0;
        end
      end
    end
    carry_out = c;
  end

  assign overflow = carry_out && (len == LEN_W'(MAX_CHARS));

  // digit/length register; an overflowing advance leaves the last value in place
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digits <= '0;
      len    <= LEN_W'(1);
    end else if (load) begin
      digits <= '0;
      len    <= LEN_W'(1);
    end else if (advance && !overflow) begin
      digits <= nxt_digits;   // all zero on a length carry
      if (carry_out) len <= len + LEN_W'(1);
    end
  end

endmodule

// File: rtl/candidate_generator.sv
// Candidate source: seeks to a start offset, then emits every stride-th
// candidate over valid/ready until the MAX_CHARS space is used up.
module candidate_generator
  import md5_pkg::*;
#(
  parameter int MAX_CHARS = MAX_CHARS_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   start_position,
  input  logic [2:0]   increment,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [127:0] guess,
  output logic [7:0]   num_bits,
  output logic         busy,
  output logic         exhausted
);

  gen_state_t                      state, nxt_state;
  logic [7:0]                      remaining, nxt_remaining;
  logic [2:0]                      stride;
  logic                            load, advance, overflow;
  logic [MAX_CHARS-1:0][IDX_W-1:0] digits;
  logic [LEN_W-1:0]                len;
  logic                            show;

  charset_odometer #(.MAX_CHARS(MAX_CHARS)) u_odo (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .advance  (advance),
    .digits   (digits),
    .len      (len),
    .overflow (overflow)
  );

  // state, countdown and captured stride
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      stride    <= 3'd1;
    end else begin
      state     <= nxt_state;
      remaining <= nxt_remaining;
      if (load) stride <= (increment == 3'd0) ? 3'd1 : increment;
    end
  end

  // next state, odometer control; any overflowing advance lands in DONE
  always_comb begin
    nxt_state     = state;
    nxt_remaining = remaining;
    load          = 1'b0;
    advance       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load          = 1'b1;
          nxt_remaining = start_position;
          nxt_state     = ST_SEEK;
        end
      end
      ST_SEEK: begin
        if (remaining != 8'd0) begin
          advance       = 1'b1;
          nxt_remaining = remaining - 8'd1;
          if (overflow) nxt_state = ST_DONE;
        end else begin
          nxt_state = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          advance = 1'b1;
          if (overflow) nxt_state = ST_DONE;
          else if (stride != 3'd1) begin
            nxt_state     = ST_STEP;
            nxt_remaining = 8'(stride) - 8'd2;
          end
        end
      end
      ST_STEP: begin
        advance = 1'b1;
        if (overflow)                nxt_state = ST_DONE;
        else if (remaining == 8'd0)  nxt_state = ST_EMIT;
        else                         nxt_remaining = remaining - 8'd1;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  assign out_valid = (state == ST_EMIT);
  assign busy      = (state == ST_SEEK) || (state == ST_EMIT) || (state == ST_STEP);
  assign exhausted = (state == ST_DONE);
  assign show      = (state == ST_EMIT) || (state == ST_DONE);
  assign num_bits  = show ? {len, 3'b000} : 8'd0;

  // right-aligned ASCII decode of the registered digits
  always_comb begin
    guess = '0;
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (show && (i < int'(len))) guess[8*i +: 8] = idx_to_ascii(digits[i]);
    end
  end

endmodule

// File: tb/tb_candidate_generator.sv
// Directed bench: a default-size generator plus a MAX_CHARS=2 copy for the
// exhaustion case, both fed the same inputs.
module tb_candidate_generator;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   start_position = 8'd0;
  logic [2:0]   increment = 3'd1;
  logic         out_ready = 1'b0;
  logic         out_valid, busy, exhausted;
  logic [127:0] guess;
  logic [7:0]   num_bits;
  logic         out_valid2, busy2, exhausted2;
  logic [127:0] guess2;
  logic [7:0]   num_bits2;

  int asserts = 0;
  int errors  = 0;

  string cs = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  always #5 clock = ~clock;

  candidate_generator dut (
    .clock(clock), .reset(reset), .start(start), .start_position(start_position),
    .increment(increment), .out_ready(out_ready), .out_valid(out_valid),
    .guess(guess), .num_bits(num_bits), .busy(busy), .exhausted(exhausted)
  );

  candidate_generator #(.MAX_CHARS(2)) dut2 (
    .clock(clock), .reset(reset), .start(start), .start_position(start_position),
    .increment(increment), .out_ready(out_ready), .out_valid(out_valid2),
    .guess(guess2), .num_bits(num_bits2), .busy(busy2), .exhausted(exhausted2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // leaves time at #1 after the edge that samples start
  task automatic pulse_start(input logic [7:0] sp, input logic [2:0] inc);
    start_position = sp;
    increment      = inc;
    start          = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    asserts++;
    if ({out_valid, busy, exhausted} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {out_valid, busy, exhausted});
    end
    asserts++;
    if (guess !== 128'd0) begin errors++; $display("FAIL reset_guess got %h want 0", guess); end
    asserts++;
    if (num_bits !== 8'd0) begin errors++; $display("FAIL reset_num_bits got %0d want 0", num_bits); end
    tick();
    reset = 1'b1;
    tick();
    asserts++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_single_stride();
    logic [127:0] exp_g;
    do_reset();
    out_ready = 1'b1;
    pulse_start(8'd0, 3'd1);
    asserts++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL seek_after_e0 valid=%b busy=%b want 0 1", out_valid, busy);
    end
    tick();
    for (int k = 0; k < 64; k++) begin
      if (k < 62) exp_g = {120'd0, cs[k]};
      else        exp_g = {112'd0, 8'h61, cs[k-62]};
      asserts++;
      if (out_valid !== 1'b1 || guess !== exp_g || num_bits !== ((k < 62) ? 8'd8 : 8'd16)) begin
        errors++;
        $display("FAIL seq1_k%0d valid=%b guess=%h bits=%0d want 1 %h %0d",
                 k, out_valid, guess, num_bits, exp_g, (k < 62) ? 8 : 16);
      end
      tick();
    end
  endtask

  task automatic test_stride3();
    logic [7:0] exp_c [3];
    exp_c = '{8'h62, 8'h65, 8'h68};
    do_reset();
    out_ready = 1'b1;
    pulse_start(8'd1, 3'd3);
    increment      = 3'd1;   // must not affect the running sequence
    start_position = 8'd7;
    tick();
    tick();
    for (int c = 0; c < 3; c++) begin
      asserts++;
      if (out_valid !== 1'b1 || guess !== {120'd0, exp_c[c]}) begin
        errors++; $display("FAIL stride3_c%0d valid=%b guess=%h want 1 %h", c, out_valid, guess, exp_c[c]);
      end
      tick();
      asserts++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL stride3_gap1_c%0d valid=%b busy=%b want 0 1", c, out_valid, busy);
      end
      tick();
      asserts++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL stride3_gap2_c%0d valid=%b want 0", c, out_valid); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    pulse_start(8'd2, 3'd1);
    tick();
    tick();
    tick();
    for (int n = 0; n < 5; n++) begin
      asserts++;
      if (out_valid !== 1'b1 || guess !== 128'h63 || num_bits !== 8'd8) begin
        errors++; $display("FAIL hold_n%0d valid=%b guess=%h bits=%0d want 1 63 8", n, out_valid, guess, num_bits);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    asserts++;
    if (out_valid !== 1'b1 || guess !== 128'h64) begin
      errors++; $display("FAIL release valid=%b guess=%h want 1 64", out_valid, guess);
    end
  endtask

  task automatic test_exhaust();
    int cnt = 0, cyc = 0;
    logic [127:0] first_g = '0, last_g = '0;
    logic [7:0]   last_b = '0;
    do_reset();
    out_ready = 1'b1;
    pulse_start(8'd0, 3'd1);
    tick();
    while (!exhausted2 && cyc < 5000) begin
      if (out_valid2) begin
        if (cnt == 0) first_g = guess2;
        cnt++;
        last_g = guess2;
        last_b = num_bits2;
      end
      cyc++;
      tick();
    end
    asserts++;
    if (exhausted2 !== 1'b1) begin errors++; $display("FAIL exhaust_timeout exhausted=%b want 1", exhausted2); end
    asserts++;
    if (cnt != 3906) begin errors++; $display("FAIL exhaust_count got %0d want 3906", cnt); end
    asserts++;
    if (first_g !== 128'h61) begin errors++; $display("FAIL exhaust_first got %h want 61", first_g); end
    asserts++;
    if (last_g !== 128'h3939 || last_b !== 8'd16) begin
      errors++; $display("FAIL exhaust_last got %h/%0d want 3939/16", last_g, last_b);
    end
    tick();
    asserts++;
    if (out_valid2 !== 1'b0 || exhausted2 !== 1'b1 || busy2 !== 1'b0) begin
      errors++; $display("FAIL done_flags valid=%b exh=%b busy=%b want 0 1 0", out_valid2, exhausted2, busy2);
    end
    asserts++;
    if (guess2 !== 128'h3939) begin errors++; $display("FAIL done_hold got %h want 3939", guess2); end
    pulse_start(8'd0, 3'd1);
    tick();
    asserts++;
    if (out_valid2 !== 1'b1 || guess2 !== 128'h61 || num_bits2 !== 8'd8 || exhausted2 !== 1'b0) begin
      errors++; $display("FAIL restart valid=%b guess=%h bits=%0d exh=%b want 1 61 8 0",
                         out_valid2, guess2, num_bits2, exhausted2);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    do_reset();
    out_ready = 1'b1;
    pulse_start(8'd0, 3'd2);
    tick();
    tick();
    asserts++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL in_step busy=%b valid=%b want 1 0", busy, out_valid);
    end
    #2 reset = 1'b0;
    #1;
    asserts++;
    if ({out_valid, busy, exhausted} !== 3'b000 || guess !== 128'd0 || num_bits !== 8'd0) begin
      errors++; $display("FAIL async_reset flags=%b guess=%h bits=%0d want 000 0 0",
                         {out_valid, busy, exhausted}, guess, num_bits);
    end
    tick();
    reset = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    asserts++;
    if (bad != 0) begin errors++; $display("FAIL post_reset_quiet got %0d active cycles want 0", bad); end
  endtask

  task automatic test_inc0_start_ignored();
    do_reset();
    out_ready = 1'b1;
    pulse_start(8'd0, 3'd0);
    tick();
    asserts++;
    if (out_valid !== 1'b1 || guess !== 128'h61) begin
      errors++; $display("FAIL inc0_first valid=%b guess=%h want 1 61", out_valid, guess);
    end
    start_position = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 5; k++) begin
      asserts++;
      if (out_valid !== 1'b1 || guess !== {120'd0, cs[k]}) begin
        errors++; $display("FAIL inc0_k%0d valid=%b guess=%h want 1 %h", k, out_valid, guess, cs[k]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_stride();
    test_stride3();
    test_backpressure();
    test_exhaust();
    test_reset_mid();
    test_inc0_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

endmodule
